// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits MSB first, parity, stop; 16x oversampling with internal baud divider.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchroniser on RxD.
module uart_receiver #(
    parameter int CLK_FREQ = 50000000,
    parameter int OSR      = 16
) (
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       test_parity,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_BUSY
);

    localparam int DIV_W = $clog2(CLK_FREQ / (OSR * 300) + 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic [DIV_W-1:0] div_terminal(input logic [2:0] sel);
        int baud;
        int div;
        case (sel)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        div = CLK_FREQ / (OSR * baud);
        if (div < 1) div = 1;
        return DIV_W'(div - 1);
    endfunction

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             perr_q, perr_d;
    logic             rxd_prev_q;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_perror_q, rx_perror_d;
    logic             rx_ferror_q, rx_ferror_d;
    logic             rxd_s;
    logic             sample_tick;
    logic             start_edge;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], RxD};
    end

    assign rxd_s = sync_q[1];
`else
    assign rxd_s = RxD;
`endif

    assign sample_tick = (div_cnt_q == div_terminal(baud_select));
    assign start_edge  = rxd_prev_q & ~rxd_s;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = sample_tick ? '0 : div_cnt_q + 1'b1;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_perror_d = rx_perror_q;
        rx_ferror_d = rx_ferror_q;

        if (!Rx_EN) begin
            // Partial frame is dropped; published byte and flags are kept.
            state_d    = IDLE;
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_d    = START;
                        div_cnt_d  = '0;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (tick_cnt_q == 4'd7) begin
                            tick_cnt_d = '0;
                            bit_idx_d  = '0;
                            state_d    = rxd_s ? IDLE : DATA;
                        end else begin
                            tick_cnt_d = tick_cnt_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            shift_d   = {shift_q[6:0], rxd_s};
                            bit_idx_d = bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (sample_tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            perr_d  = rxd_s ^ (^shift_q) ^ test_parity;
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                        if (tick_cnt_q == 4'd15) begin
                            rx_data_d   = shift_q;
                            rx_perror_d = perr_q;
                            rx_ferror_d = ~rxd_s;
                            rx_valid_d  = 1'b1;
                            tick_cnt_d  = '0;
                            state_d     = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            perr_q      <= 1'b0;
            rxd_prev_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_perror_q <= 1'b0;
            rx_ferror_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            perr_q      <= perr_d;
            rxd_prev_q  <= rxd_s;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_perror_q <= rx_perror_d;
            rx_ferror_q <= rx_ferror_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign Rx_DATA   = rx_data_q;
    assign Rx_VALID  = rx_valid_q;
    assign Rx_PERROR = rx_perror_q;
    assign Rx_FERROR = rx_ferror_q;
    assign Rx_BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 50 MHz, 115200 baud (DIV=27, 432 clk per bit).
module tb_uart_receiver;

    localparam int BIT = 16 * 27;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       reset;
    logic       clk;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       test_parity;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;
    logic       Rx_BUSY;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   valid_cnt = 0;
    int   exp_valid = 0;

    uart_receiver #(.CLK_FREQ(50000000), .OSR(16)) dut (
        .reset       (reset),
        .clk         (clk),
        .baud_select (baud_select),
        .Rx_EN       (Rx_EN),
        .test_parity (test_parity),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR),
        .Rx_BUSY     (Rx_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard side: every valid pulse pops one expected frame.
    always @(negedge clk) begin
        if (!reset && Rx_VALID) begin
            valid_cnt++;
            check("busy_at_valid", Rx_BUSY, 0);
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rx_data", Rx_DATA, e.data);
                check("rx_perror", Rx_PERROR, e.perr);
                check("rx_ferror", Rx_FERROR, e.ferr);
            end
        end
    end

    task automatic line_bit(input logic b);
        RxD = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        exp_t e;
        e.data = d;
        e.perr = par ^ (^d) ^ test_parity;
        e.ferr = ~stp;
        sb_q.push_back(e);
        exp_valid++;
        line_bit(1'b0);
        for (int i = 7; i >= 0; i--) line_bit(d[i]);
        line_bit(par);
        line_bit(stp);
    endtask

    task automatic idle_gap(input int n);
        RxD = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #(10 * 2000000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vc;
        reset       = 1'b1;
        baud_select = 3'd7;
        Rx_EN       = 1'b1;
        test_parity = 1'b0;
        RxD         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", Rx_DATA, 0);
        check("reset_valid", Rx_VALID, 0);
        check("reset_perr", Rx_PERROR, 0);
        check("reset_ferr", Rx_FERROR, 0);
        check("reset_busy", Rx_BUSY, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle_gap(50);

        send_frame(8'hA5, 1'b0, 1'b1);
        idle_gap(300);
        check("busy_after_a5", Rx_BUSY, 0);

        send_frame(8'hA5, 1'b1, 1'b1);
        idle_gap(300);
        check("perr_sticky", Rx_PERROR, 1);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_gap(300);

        test_parity = 1'b1;
        send_frame(8'h01, 1'b0, 1'b1);
        idle_gap(300);
        send_frame(8'h01, 1'b1, 1'b1);
        idle_gap(300);
        test_parity = 1'b0;

        send_frame(8'hFF, 1'b0, 1'b0);
        idle_gap(300);

        // 4-tick glitch must be rejected as a false start.
        vc = valid_cnt;
        RxD = 1'b0;
        repeat (4 * 27) @(posedge clk);
        #1;
        check("busy_in_glitch", Rx_BUSY, 1);
        idle_gap(16 * 27);
        check("glitch_busy", Rx_BUSY, 0);
        check("glitch_novalid", valid_cnt, vc);
        check("glitch_ferr_kept", Rx_FERROR, 1);
        check("glitch_data_kept", Rx_DATA, 8'hFF);

        // Disable mid fourth data bit of 0x96.
        vc = valid_cnt;
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b0);
        line_bit(1'b0);
        RxD = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("busy_before_dis", Rx_BUSY, 1);
        Rx_EN = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_dis", Rx_BUSY, 0);
        idle_gap(BIT * 8);
        check("abort_novalid", valid_cnt, vc);
        check("abort_data_kept", Rx_DATA, 8'hFF);
        Rx_EN = 1'b1;
        idle_gap(50);

        send_frame(8'h5A, 1'b0, 1'b1);
        idle_gap(300);

        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1);
        idle_gap(600);

        check("sb_empty", sb_q.size(), 0);
        check("valid_count", valid_cnt, exp_valid);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
